// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LS memory port arbiter: access sizes, owner states, defaults.
package mem_pkg;

    localparam int MEM_AW_DEFAULT = 11;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OWN_IF    = 2'd1,
        OWN_LS_RD = 2'd2,
        OWN_LS_WR = 2'd3
    } mem_owner_e;

    // The reserved size encoding 3 is serviced as a full word.
    function automatic mem_size_e norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SIZE_WORD : mem_size_e'(size);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side bus of the arbiter; slave = arbiter, master = requesters + memory.
interface mem_port_arbiter_if;

    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;

    logic        ls_req_valid;
    logic [31:0] ls_req_addr;
    logic        ls_req_we;
    logic [1:0]  ls_req_size;
    logic        ls_req_sext;
    logic [31:0] ls_req_wdata;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;

    logic        mem_clk_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_offset_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_sext;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  if_req_valid, if_req_addr,
        input  ls_req_valid, ls_req_addr, ls_req_we, ls_req_size, ls_req_sext, ls_req_wdata,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output mem_clk_enable, mem_addr, mem_offset_addr, mem_wdata, mem_we, mem_size, mem_sext,
        output busy
    );

    modport master (
        output if_req_valid, if_req_addr,
        output ls_req_valid, ls_req_addr, ls_req_we, ls_req_size, ls_req_sext, ls_req_wdata,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  mem_clk_enable, mem_addr, mem_offset_addr, mem_wdata, mem_we, mem_size, mem_sext,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating 4-bit counter of consecutive cycles the fetch side lost arbitration.
module starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [3:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && count != 4'(LIMIT)) begin
            count <= count + 4'd1;
        end
    end

    assign at_limit = (count == 4'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (IF) and load/store (LS); LS has priority, IF is starvation-protected.
// Optional statistics counters are enabled with `define MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MEM_AW       = MEM_AW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    output logic [31:0]          stat_if_grants,
    output logic [31:0]          stat_ls_grants,
    output logic [31:0]          stat_conflicts
`endif
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || MEM_AW < 2 || MEM_AW > 32) begin : g_param_check
        $error("mem_port_arbiter: STARVE_LIMIT must be 1..15 and MEM_AW 2..32");
    end

    mem_owner_e  state;
    logic        starve_at_limit;
    logic        if_grant;
    logic        ls_grant;

    logic [31:0] addr_q;
    mem_size_e   size_q;
    logic        sext_q;

    logic [31:0] sel_addr;
    mem_size_e   sel_size;
    logic        sel_sext;
    logic [31:0] sel_wdata;

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (bus.if_req_valid && ls_grant),
        .clr      (if_grant || !bus.if_req_valid),
        .at_limit (starve_at_limit)
    );

    // Grants are suppressed while reset is held so ready/enable read as 0 immediately.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        if_grant = 1'b0;
        ls_grant = 1'b0;
        if (!rst) begin
            if (bus.ls_req_valid && !(bus.if_req_valid && starve_at_limit)) begin
                ls_grant = 1'b1;
            end else if (bus.if_req_valid) begin
                if_grant = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr  = addr_q;
        sel_size  = size_q;
        sel_sext  = sext_q;
        sel_wdata = 32'd0;
        if (ls_grant) begin
            sel_addr  = bus.ls_req_addr;
            sel_size  = norm_size(bus.ls_req_size);
            sel_sext  = bus.ls_req_sext;
            sel_wdata = bus.ls_req_wdata;
        end else if (if_grant) begin
            sel_addr  = bus.if_req_addr;
            sel_size  = SIZE_WORD;
            sel_sext  = 1'b0;
        end
    end

    // Owner FSM plus the held address/size/sext that keep the memory's swizzle state stable when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= 32'd0;
            size_q <= SIZE_WORD;
            sext_q <= 1'b0;
        end else begin
            if (ls_grant) begin
                state <= bus.ls_req_we ? OWN_LS_WR : OWN_LS_RD;
            end else if (if_grant) begin
                state <= OWN_IF;
            end else begin
                state <= IDLE;
            end
            addr_q <= sel_addr;
            size_q <= sel_size;
            sext_q <= sel_sext;
        end
    end

    assign bus.if_req_ready    = if_grant;
    assign bus.ls_req_ready    = ls_grant;
    assign bus.mem_clk_enable  = if_grant || ls_grant;
    assign bus.mem_we          = ls_grant && bus.ls_req_we;
    assign bus.mem_addr        = sel_addr;
    assign bus.mem_offset_addr = {sel_addr[31:2] + 30'd1, 2'b00};
    assign bus.mem_size        = sel_size;
    assign bus.mem_sext        = sel_sext;
    assign bus.mem_wdata       = sel_wdata;

    // Read data arrives one cycle after the grant; the owner state steers it.
    assign bus.if_rsp_valid = (state == OWN_IF);
    assign bus.if_rsp_data  = (state == OWN_IF) ? bus.mem_rdata : 32'd0;
    assign bus.ls_rsp_valid = (state == OWN_LS_RD) || (state == OWN_LS_WR);
    assign bus.ls_rsp_data  = (state == OWN_LS_RD) ? bus.mem_rdata : 32'd0;
    assign bus.busy         = (state != IDLE);

`ifdef MEM_PORT_ARBITER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_if_grants <= 32'd0;
            stat_ls_grants <= 32'd0;
            stat_conflicts <= 32'd0;
        end else begin
            if (if_grant) stat_if_grants <= stat_if_grants + 32'd1;
            if (ls_grant) stat_ls_grants <= stat_ls_grants + 32'd1;
            if (bus.if_req_valid && bus.ls_req_valid) stat_conflicts <= stat_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported data/instruction memory between the fetch stage (IF) and the load/store stage (LS).
- Per cycle it grants at most one request and drives the memory's address, offset address, write data and access controls.
- Routes the 1-cycle-latency read data back to whichever requester owned that access.
- LS has priority; a starvation counter guarantees fetch forward progress.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles IF may lose arbitration before it is forced to win (1..15).
- MEM_AW, 11: byte-address bits the memory decodes; higher address bits are ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  32  fetch byte address (word access, no sign-extension)
- if_req_ready  out  1  fetch request granted this cycle
- if_rsp_valid  out  1  fetch data valid
- if_rsp_data  out  32  fetch data
- ls_req_valid  in  1  load/store request
- ls_req_addr  in  32  load/store byte address
- ls_req_we  in  1  1 = store
- ls_req_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
- ls_req_sext  in  1  sign-extend a load
- ls_req_wdata  in  32  store data
- ls_req_ready  out  1  LS request granted this cycle
- ls_rsp_valid  out  1  LS response (load data, or store ack with data 0)
- ls_rsp_data  out  32  load data
- mem_clk_enable  out  1  memory pipeline advance
- mem_addr  out  32  access address
- mem_offset_addr  out  32  {mem_addr[31:2]+1, 2'b00}, for word-crossing accesses
- mem_wdata  out  32  store data
- mem_we  out  1  write enable
- mem_size  out  2  access size
- mem_sext  out  1  sign-extend
- mem_rdata  in  32  memory read data, valid the cycle after the access
- busy  out  1  access in flight

Behaviour:
- Grant (combinational from the current request lines and registered state):
  - Only LS valid: LS wins.
  - Only IF valid: IF wins.
  - Both valid: LS wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - Exactly one of if_req_ready / ls_req_ready is high, and only when the granted side is valid.
- Grant cycle: mem_clk_enable = 1; mem_* driven from the winner.
  - IF winner: mem_we = 0, mem_size = 2, mem_sext = 0, mem_wdata = 0.
- No grant: mem_clk_enable = 0, mem_we = 0; mem_addr/size/sext hold their last granted values, so the output swizzle state stays consistent.
- starve_cnt (4-bit):
  - Increments when IF is valid and LS is granted.
  - Clears when IF is granted or IF is not valid.
  - Saturates at STARVE_LIMIT.
- Owner FSM, registered on every clk edge:
  - States: IDLE, OWN_IF, OWN_LS_RD, OWN_LS_WR.
  - The next state is set by this cycle's grant (IF → OWN_IF; LS load → OWN_LS_RD; LS store → OWN_LS_WR); no grant → IDLE.
  - Any state may transition to any state, so back-to-back accesses run at one per cycle.
- Responses, 1-cycle latency:
  - OWN_IF: if_rsp_valid = 1, if_rsp_data = mem_rdata.
  - OWN_LS_RD: ls_rsp_valid = 1, ls_rsp_data = mem_rdata.
  - OWN_LS_WR: ls_rsp_valid = 1, ls_rsp_data = 0.
  - Otherwise both rsp_valid = 0 and both rsp_data = 0.
  - Responses have no backpressure; requesters must accept them.
- busy = (state != IDLE).
- Address width: only mem_addr[MEM_AW-1:0] is meaningful downstream. mem_offset_addr wraps modulo 2^32.
- Same-cycle store to address A followed by a load from A: ordering is preserved by grant order; the load is issued after the store's grant cycle.
- Reset values (apply immediately, asynchronously):
  - state = IDLE, starve_cnt = 0.
  - mem_addr = 0, mem_size = 2, mem_sext = 0.
  - All valid/ready/we/enable outputs = 0; all data outputs = 0.
- Reset mid-access: the in-flight response is dropped and never reported.

Optional Feature:
- MEM_PORT_ARBITER_STATS_EN: adds outputs stat_if_grants[31:0], stat_ls_grants[31:0] and stat_conflicts[31:0].
  - stat_conflicts counts cycles with both requests valid.
  - All three counters wrap, and reset to 0.
- Without the macro, the ports and counters do not exist.

Decomposition:
- Shared package mem_pkg holds:
  - mem_size_e enum (SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2).
  - mem_owner_e enum for the FSM states.
  - Constant MEM_AW_DEFAULT = 11.
- One sub-module, starve_counter: saturating counter with inc/clr inputs and an at_limit output.

Test Plan:
- IF only, addr 0x10, mem_rdata 0xDEADBEEF next cycle → if_req_ready = 1 in cycle 0, if_rsp_valid = 1 with 0xDEADBEEF in cycle 1, ls_rsp_valid = 0.
- LS store addr 0x7FE, wdata 0x1234, size half → mem_we = 1, mem_size = 1, mem_offset_addr = 0x800; next cycle ls_rsp_valid = 1, ls_rsp_data = 0.
- IF and LS both valid continuously, STARVE_LIMIT = 4 → grants LS, LS, LS, LS, IF, repeating; IF never waits more than 4 cycles.
- Back-to-back LS load 0x20 then IF 0x24 → responses in consecutive cycles, each routed to the correct port, no bubble.
- Assert rst in the cycle after a load grant → no ls_rsp_valid; state IDLE and outputs at reset values immediately.
- No requests for 3 cycles after an access to 0x103 size byte → mem_clk_enable = 0, mem_addr stays 0x103, busy = 0.
